// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are computed at acceptance and committed after a fixed busy window.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        sel_hi,
  output logic        busy,
  output logic [31:0] result,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_RUN} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              busy_q;
  logic [31:0]       hi_q, lo_q;
  logic [31:0]       pend_hi_q, pend_lo_q;
  logic              pend_wr_q;

  logic [31:0]       pend_hi_d, pend_lo_d;
  logic              pend_wr_d;
  logic [CNT_W-1:0]  cnt_d;

  logic              is_signed;
  logic [63:0]       mul_a, mul_b, prod;
  logic              a_neg, b_neg, div_zero;
  logic [31:0]       a_mag, b_mag, quo, rem;

  // Operand datapath: ops 0..3 are signed when op[0]=0, divide when op[1]=1.
  always_comb begin
    is_signed = ~op[0];
    mul_a     = {(is_signed ? {32{A[31]}} : 32'h0), A};
    mul_b     = {(is_signed ? {32{B[31]}} : 32'h0), B};
    prod      = mul_a * mul_b;

    div_zero  = (B == 32'h0);
    a_neg     = is_signed & A[31];
    b_neg     = is_signed & B[31];
    a_mag     = a_neg ? (32'h0 - A) : A;
    b_mag     = div_zero ? 32'h1 : (b_neg ? (32'h0 - B) : B);
    quo       = a_mag / b_mag;
    rem       = a_mag % b_mag;

    if (op[1]) begin
      pend_lo_d = (a_neg ^ b_neg) ? (32'h0 - quo) : quo;
      pend_hi_d = a_neg ? (32'h0 - rem) : rem;
      pend_wr_d = ~div_zero;
      cnt_d     = CNT_W'(DIV_CYCLES);
    end else begin
      pend_lo_d = prod[31:0];
      pend_hi_d = prod[63:32];
      pend_wr_d = 1'b1;
      cnt_d     = CNT_W'(MULT_CYCLES);
    end
  end

  // Control FSM and architectural registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      hi_q      <= 32'h0;
      lo_q      <= 32'h0;
      pend_hi_q <= 32'h0;
      pend_lo_q <= 32'h0;
      pend_wr_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MTHI: hi_q <= A;
              OP_MTLO: lo_q <= A;
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                pend_hi_q <= pend_hi_d;
                pend_lo_q <= pend_lo_d;
                pend_wr_q <= pend_wr_d;
                cnt_q     <= cnt_d;
                busy_q    <= 1'b1;
                state_q   <= S_RUN;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            pend_wr_q <= 1'b0;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  assign result = sel_hi ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases with literal expectations plus
// randomized traffic compared every cycle against a transaction-level model.
module tb_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        rst, start, sel_hi;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] result, hi, lo;

  mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .A(A), .B(B),
    .sel_hi(sel_hi), .busy(busy), .result(result), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model: architectural HI/LO plus remaining busy cycles and the result to land.
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_wr = 0;
  int          m_rem = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(posedge clk) begin
    longint          sa, sb, sq, sr;
    longint unsigned ua, ub;
    if (rst) begin
      m_hi = 0; m_lo = 0; m_rem = 0; m_wr = 0;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_wr) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (start) begin
      sa = {{32{A[31]}}, A}; sb = {{32{B[31]}}, B};
      ua = {32'h0, A};       ub = {32'h0, B};
      case (op)
        3'd0: begin sq = sa * sb; m_phi = sq[63:32]; m_plo = sq[31:0]; m_wr = 1; m_rem = MC; end
        3'd1: begin ua = ua * ub; m_phi = ua[63:32]; m_plo = ua[31:0]; m_wr = 1; m_rem = MC; end
        3'd2: begin
          m_rem = DC; m_wr = (B != 0);
          if (B != 0) begin sq = sa / sb; sr = sa % sb; m_plo = sq[31:0]; m_phi = sr[31:0]; end
        end
        3'd3: begin
          m_rem = DC; m_wr = (B != 0);
          if (B != 0) begin m_plo = 32'(ua / ub); m_phi = 32'(ua % ub); end
        end
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        default: ;
      endcase
    end
  end

  // Every-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   32'(busy), 32'(m_rem > 0));
      check("hi",     hi, m_hi);
      check("lo",     lo, m_lo);
      check("result", result, sel_hi ? m_hi : m_lo);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; A = a; B = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 100) begin step(); n++; end
    if (n >= 100) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %b after 100 cycles", busy);
    end
  endtask

  task automatic expect_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    check({name, "_hi"}, hi, eh);
    check({name, "_lo"}, lo, el);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; op = 3'd0; A = 0; B = 0; sel_hi = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_en = 1'b1;
    expect_hilo("reset", 32'h0, 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_res_lo", result, 32'h0);
    sel_hi = 1'b1; #1;
    check("reset_res_hi", result, 32'h0);

    // MULT -3*5: busy for exactly 5 cycles
    issue(3'd0, 32'hFFFF_FFFD, 32'd5);
    for (int i = 0; i < MC; i++) begin
      check("mult_busy_window", 32'(busy), 32'h1);
      step();
    end
    check("mult_busy_fall", 32'(busy), 32'h0);
    expect_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFF1);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2); wait_idle();
    expect_hilo("multu", 32'h1, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    for (int i = 0; i < DC; i++) begin
      check("div_busy_window", 32'(busy), 32'h1);
      step();
    end
    check("div_busy_fall", 32'(busy), 32'h0);
    expect_hilo("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd4, 32'h11, 32'h0);
    issue(3'd5, 32'h22, 32'h0);
    issue(3'd3, 32'd7, 32'd0); wait_idle();
    expect_hilo("divu_by_zero", 32'h11, 32'h22);

    // start during busy is ignored; operand changes mid-busy have no effect
    issue(3'd0, 32'd3, 32'd4);
    step();
    issue(3'd5, 32'h99, 32'h0);
    A = 32'h1234; B = 32'h5678;
    wait_idle();
    expect_hilo("ignored_start", 32'h0, 32'd12);

    issue(3'd4, 32'hDEAD_BEEF, 32'h0);
    check("mthi_busy", 32'(busy), 32'h0);
    sel_hi = 1'b1; #1;
    check("mthi_result", result, 32'hDEAD_BEEF);
    issue(3'd5, 32'd5, 32'h0);
    check("mtlo_lo", lo, 32'd5);
    issue(3'd0, 32'd6, 32'd7);
    check("back_to_back_busy", 32'(busy), 32'h1);
    wait_idle();
    expect_hilo("back_to_back", 32'h0, 32'd42);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    expect_hilo("div_overflow", 32'h0, 32'h8000_0000);

    // reset mid-divide aborts it
    issue(3'd2, 32'd100, 32'd7);
    step(); step(); step();
    rst = 1'b1; step(); rst = 1'b0;
    check("abort_busy", 32'(busy), 32'h0);
    expect_hilo("abort", 32'h0, 32'h0);
    for (int i = 0; i < DC + 2; i++) step();
    expect_hilo("abort_late", 32'h0, 32'h0);

    rst = 1'b1; start = 1'b1; op = 3'd4; A = 32'h5;
    step();
    rst = 1'b0; start = 1'b0;
    check("rst_start_hi", hi, 32'h0);

    // randomized traffic, including starts while busy and occasional resets
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 199) == 0);
      start  = ($urandom_range(0, 2) == 0);
      op     = 3'($urandom_range(0, 7));
      A      = pick();
      B      = pick();
      sel_hi = 1'($urandom_range(0, 1));
      step();
    end
    rst = 1'b0; start = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
